// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// instruction field constants, ALU codes and datapath mux encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_R_WB,
    ST_MEM_ADDR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_BRANCH,
    ST_JUMP,
    ST_EXEC_I,
    ST_I_WB,
    ST_HALT
  } state_t;

  // Operation class handed to the ALU decoder; selects where alu_op comes from.
  typedef enum logic [1:0] {
    CLS_ADDR,    // address / increment arithmetic, always ADD
    CLS_BRANCH,  // equality compare, always SUB
    CLS_RTYPE,   // decoded from funct
    CLS_ITYPE    // decoded from opcode
  } alu_class_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_SLTI = 6'h0A;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SIMM = 2'b10;
  localparam logic [1:0] SRCB_ZIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Logical immediates are zero-extended; arithmetic ones are sign-extended.
  function automatic logic uses_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the control FSM (master) and the datapath (slave).
interface mc_control_fsm_if #(
  parameter int unsigned cw = 32
);
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic          mem_ready;
  logic          pc_en;
  logic          iord;
  logic          mem_read;
  logic          mem_write;
  logic          ir_write;
  logic          reg_dst;
  logic          mem_to_reg;
  logic          reg_write;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [2:0]    alu_op;
  logic [1:0]    pc_source;
  logic          illegal;
  logic [cw-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, retired
  );
endinterface

// File: rtl/mc_control_fsm_alu_decode.sv
// ALU function decoder: maps operation class plus IR fields to an ALU code
// and flags funct/opcode values the ALU does not support.
module alu_decode
  import mips_ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_op,
  output logic        valid
);

  // Select the ALU function for the requested class
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (alu_class)
      CLS_ADDR:   alu_op = ALU_ADD;
      CLS_BRANCH: alu_op = ALU_SUB;
      CLS_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: valid  = 1'b0;
        endcase
      end
      CLS_ITYPE: begin
        case (opcode)
          OP_ADDI: alu_op = ALU_ADD;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_SLTI: alu_op = ALU_SLT;
          default: valid  = 1'b0;
        endcase
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/write-back, with sticky illegal-instruction flag and retire counter.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned cw = 32
) (
  input  logic               clk,
  input  logic               rst,
  mc_control_fsm_if.master   bus
);

  state_t        state;
  state_t        state_next;
  alu_class_t    alu_class;
  logic [2:0]    dec_alu_op;
  logic          dec_valid;
  logic          retire;
  logic          illegal_q;
  logic [cw-1:0] retired_q;

  logic          pc_en;
  logic          iord;
  logic          mem_read;
  logic          mem_write;
  logic          ir_write;
  logic          reg_dst;
  logic          mem_to_reg;
  logic          reg_write;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [2:0]    alu_op;
  logic [1:0]    pc_source;

  assign alu_class = (state == ST_EXEC_R) ? CLS_RTYPE  :
                     (state == ST_EXEC_I) ? CLS_ITYPE  :
                     (state == ST_BRANCH) ? CLS_BRANCH : CLS_ADDR;

  alu_decode u_alu_decode (
    .alu_class (alu_class),
    .opcode    (bus.opcode),
    .funct     (bus.funct),
    .alu_op    (dec_alu_op),
    .valid     (dec_valid)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state sequencing and opcode dispatch
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   state_next = ST_FETCH;
      ST_FETCH:  if (bus.mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OP_R:                             state_next = ST_EXEC_R;
          OP_LW, OP_SW:                     state_next = ST_MEM_ADDR;
          OP_BEQ:                           state_next = ST_BRANCH;
          OP_J:                             state_next = ST_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = ST_EXEC_I;
          default:                          state_next = ST_HALT;
        endcase
      end
      ST_EXEC_R:    state_next = dec_valid ? ST_R_WB : ST_HALT;
      ST_R_WB:      state_next = ST_FETCH;
      ST_MEM_ADDR:  state_next = (bus.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (bus.mem_ready) state_next = ST_MEM_WB;
      ST_MEM_WB:    state_next = ST_FETCH;
      ST_MEM_WRITE: if (bus.mem_ready) state_next = ST_FETCH;
      ST_BRANCH:    state_next = ST_FETCH;
      ST_JUMP:      state_next = ST_FETCH;
      ST_EXEC_I:    state_next = ST_I_WB;
      ST_I_WB:      state_next = ST_FETCH;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Datapath controls from the current state, gated only by mem_ready/zero
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_source  = PCSRC_ALU;
    retire     = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = dec_alu_op;
        ir_write  = bus.mem_ready;
        pc_en     = bus.mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_SIMM;
        alu_op    = dec_alu_op;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
      end
      ST_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SIMM;
        alu_op    = dec_alu_op;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = bus.mem_ready;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
        pc_source = PCSRC_ALUOUT;
        pc_en     = bus.zero;
        retire    = 1'b1;
      end
      ST_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
        retire    = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = uses_zext(bus.opcode) ? SRCB_ZIMM : SRCB_SIMM;
        alu_op    = dec_alu_op;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

  // Sticky illegal flag (HALT is only reachable on a bad decode) and retire count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state_next == ST_HALT) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + cw'(1);
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.iord       = iord;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_source  = pc_source;
  assign bus.illegal    = illegal_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through its
// states and compares the packed control word against hand-written values.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mc_control_fsm_if #(.cw(32)) bus();

  mc_control_fsm #(.cw(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned exp_ret = 0;

  // {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
  //  reg_write, alu_src_a, alu_src_b[1:0], alu_op[2:0], pc_source[1:0]}
  logic [15:0] obs;
  assign obs = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source};

  function automatic logic [15:0] ctl(input logic pe, io, mr, mw, irw, rd, m2r, rw, sa,
                                      input logic [1:0] sb, input logic [2:0] op,
                                      input logic [1:0] ps);
    return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] v_fetch, v_fetch_w, v_decode, v_r_wb, v_maddr, v_mread, v_mwb;
  logic [15:0] v_mwrite, v_br_t, v_br_n, v_jump, v_i_wb;

  logic [5:0] r_fn  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] r_op  [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
  logic [5:0] i_opc [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
  logic [1:0] i_sb  [4] = '{2'b10, 2'b11, 2'b11, 2'b10};
  logic [2:0] i_op  [4] = '{3'b000, 3'b010, 3'b011, 3'b100};

  initial begin
    v_fetch   = ctl(1,0,1,0,1,0,0,0,0,2'b01,3'b000,2'b00);
    v_fetch_w = ctl(0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00);
    v_decode  = ctl(0,0,0,0,0,0,0,0,0,2'b10,3'b000,2'b00);
    v_r_wb    = ctl(0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00);
    v_maddr   = ctl(0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00);
    v_mread   = ctl(0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00);
    v_mwb     = ctl(0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00);
    v_mwrite  = ctl(0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00);
    v_br_t    = ctl(1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01);
    v_br_n    = ctl(0,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01);
    v_jump    = ctl(1,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10);
    v_i_wb    = ctl(0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00);

    bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    // reset state
    tick(); tick();
    check("rst_outputs", obs, 16'h0);
    check("rst_retired", bus.retired, 0);
    check("rst_illegal", bus.illegal, 0);
    rst = 1'b0;
    #1 check("idle", obs, 16'h0);
    tick(); check("fetch_entry", obs, v_fetch);

    // R-type, every supported funct
    for (int i = 0; i < 5; i++) begin
      bus.opcode = 6'h00; bus.funct = r_fn[i];
      #1 check("r_fetch", obs, v_fetch);
      tick(); check("r_decode", obs, v_decode);
      tick(); check("r_exec", obs, ctl(0,0,0,0,0,0,0,0,1,2'b00,r_op[i],2'b00));
      tick(); check("r_wb", obs, v_r_wb);
      check("r_ret_pre", bus.retired, exp_ret);
      tick(); exp_ret++;
      check("r_retired", bus.retired, exp_ret);
    end

    // LW with 3 wait cycles in MEM_READ
    bus.opcode = 6'h23;
    #1 check("lw_fetch", obs, v_fetch);
    tick(); check("lw_decode", obs, v_decode);
    tick(); check("lw_maddr", obs, v_maddr);
    tick(); bus.mem_ready = 1'b0;
    #1 check("lw_mread1", obs, v_mread);
    tick(); check("lw_mread2", obs, v_mread);
    tick(); check("lw_mread3", obs, v_mread);
    tick(); bus.mem_ready = 1'b1;
    #1 check("lw_mread4", obs, v_mread);
    tick(); check("lw_mwb", obs, v_mwb);
    tick(); exp_ret++;
    check("lw_retired", bus.retired, exp_ret);
    check("lw_back_fetch", obs, v_fetch);

    // SW with a FETCH wait; mem_ready low in DECODE is ignored
    bus.opcode = 6'h2B; bus.mem_ready = 1'b0;
    #1 check("sw_fetch_wait", obs, v_fetch_w);
    tick(); check("sw_fetch_hold", obs, v_fetch_w);
    bus.mem_ready = 1'b1;
    #1 check("sw_fetch_rdy", obs, v_fetch);
    tick(); check("sw_decode", obs, v_decode);
    bus.mem_ready = 1'b0;
    tick(); check("sw_maddr", obs, v_maddr);
    bus.mem_ready = 1'b1;
    tick(); check("sw_mwrite", obs, v_mwrite);
    check("sw_ret_pre", bus.retired, exp_ret);
    tick(); exp_ret++;
    check("sw_retired", bus.retired, exp_ret);

    // BEQ taken, then not taken
    for (int z = 1; z >= 0; z--) begin
      bus.opcode = 6'h04; bus.zero = 1'b0;
      #1 check("beq_fetch", obs, v_fetch);
      tick(); check("beq_decode", obs, v_decode);
      tick(); bus.zero = (z == 1);
      #1 check(z == 1 ? "beq_taken" : "beq_not_taken", obs, z == 1 ? v_br_t : v_br_n);
      tick(); exp_ret++;
      check("beq_retired", bus.retired, exp_ret);
    end
    bus.zero = 1'b0;

    // J
    bus.opcode = 6'h02;
    #1 check("j_fetch", obs, v_fetch);
    tick(); check("j_decode", obs, v_decode);
    tick(); check("j_jump", obs, v_jump);
    tick(); exp_ret++;
    check("j_retired", bus.retired, exp_ret);

    // I-type: ADDI, ANDI, ORI, SLTI
    for (int i = 0; i < 4; i++) begin
      bus.opcode = i_opc[i];
      #1 check("i_fetch", obs, v_fetch);
      tick(); check("i_decode", obs, v_decode);
      tick(); check("i_exec", obs, ctl(0,0,0,0,0,0,0,0,1,i_sb[i],i_op[i],2'b00));
      tick(); check("i_wb", obs, v_i_wb);
      tick(); exp_ret++;
      check("i_retired", bus.retired, exp_ret);
    end

    // reset pulsed during a MEM_WRITE wait
    bus.opcode = 6'h2B;
    #1 check("swr_fetch", obs, v_fetch);
    tick(); tick(); tick(); bus.mem_ready = 1'b0;
    #1 check("swr_mwrite", obs, v_mwrite);
    tick(); check("swr_mwrite_wait", obs, v_mwrite);
    #2 rst = 1'b1;
    #1 check("swr_async_drop", obs, 16'h0);
    exp_ret = 0;
    check("swr_retired", bus.retired, exp_ret);
    tick(); rst = 1'b0; bus.mem_ready = 1'b1;
    #1 check("swr_idle", obs, 16'h0);
    tick(); check("swr_fetch_again", obs, v_fetch);

    // illegal opcode
    bus.opcode = 6'h3F;
    tick(); check("ill_op_decode", obs, v_decode);
    check("ill_op_pre", bus.illegal, 0);
    tick(); check("ill_op_halt", obs, 16'h0);
    check("ill_op_flag", bus.illegal, 1);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0]; bus.zero = i[1];
      tick(); check("ill_op_hold", obs, 16'h0);
      check("ill_op_sticky", bus.illegal, 1);
    end
    check("ill_op_ret", bus.retired, 0);
    rst = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    #1 check("ill_op_clear", bus.illegal, 0);
    tick(); rst = 1'b0;
    tick(); check("ill_op_fetch", obs, v_fetch);

    // illegal funct
    bus.opcode = 6'h00; bus.funct = 6'h00;
    tick(); check("ill_fn_decode", obs, v_decode);
    tick(); check("ill_fn_pre", bus.illegal, 0);
    tick(); check("ill_fn_halt", obs, 16'h0);
    check("ill_fn_flag", bus.illegal, 1);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      tick(); check("ill_fn_hold", obs, 16'h0);
      check("ill_fn_sticky", bus.illegal, 1);
    end
    rst = 1'b1;
    #1 check("ill_fn_clear", bus.illegal, 0);
    check("ill_fn_ret", bus.retired, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle main control unit for the MIPS core. It sits directly upstream of the datapath and sequences fetch, decode, execute, memory and write-back over several clocks. It drives every datapath mux, register-enable and memory strobe from the held IR fields, and stalls on memory wait-states through a ready handshake. It also flags illegal opcodes and counts retired instructions.

Parameters:
cw, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26] from the held instruction register
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, combinational in the same cycle
mem_ready  input  1  memory has completed the current read or write
pc_en  output  1  PC register enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load enable
reg_dst  output  1  write-register select: 1 = rd, 0 = rt
mem_to_reg  output  1  register write data: 1 = MDR, 0 = ALUOut
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = A register
alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = zero-extended imm
alu_op  output  3  ALU function code, driven straight to the ALU
pc_source  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
illegal  output  1  sticky flag: unsupported opcode or funct was decoded
retired  output  cw  count of completed instructions, wraps modulo 2^cw

Behaviour:
- Moore FSM. Outputs are a function of the state register only, except the gating by mem_ready and zero listed below.
- Reset:
  - state = IDLE, illegal = 0, retired = 0.
  - All outputs are 0 in IDLE.
  - IDLE -> FETCH unconditionally on the next clock.
- FETCH:
  - Drives mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD, pc_source = 00.
  - ir_write = pc_en = mem_ready.
  - Holds while mem_ready = 0. On mem_ready = 1 it goes to DECODE.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 10, alu_op = ADD, which precomputes the branch target into ALUOut.
  - Dispatches on opcode:
    - 0x00 -> EXEC_R
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08, 0x0C, 0x0D or 0x0A -> EXEC_I
    - anything else -> HALT with illegal set
- EXEC_R:
  - Drives alu_src_a = 1, alu_src_b = 00.
  - alu_op is decoded from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - Any other funct -> HALT with illegal set.
  - Otherwise -> R_WB.
- R_WB: reg_dst = 1, mem_to_reg = 0, reg_write = 1; -> FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = ADD. LW -> MEM_READ, SW -> MEM_WRITE.
- MEM_READ: mem_read = 1, iord = 1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: reg_dst = 0, mem_to_reg = 1, reg_write = 1; -> FETCH.
- MEM_WRITE: mem_write = 1, iord = 1. Holds until mem_ready, then -> FETCH.
  - mem_write stays asserted for every wait cycle.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = SUB, pc_source = 01, pc_en = zero; -> FETCH.
- JUMP: pc_source = 10, pc_en = 1; -> FETCH.
- EXEC_I:
  - alu_src_a = 1.
  - alu_src_b = 11 for ANDI and ORI, 10 for ADDI and SLTI.
  - alu_op = ADD, AND, OR or SLT respectively.
  - -> I_WB.
- I_WB: reg_dst = 0, mem_to_reg = 0, reg_write = 1; -> FETCH.
- HALT:
  - Absorbing state; all outputs 0 and illegal stays 1.
  - Only rst leaves HALT.
- retired increments by 1 on the final-state exit clock of R_WB, MEM_WB, MEM_WRITE (with mem_ready), BRANCH, JUMP and I_WB.
- Cycles per instruction with mem_ready held at 1: R 4, LW 5, SW 4, BEQ 3, J 3, I-type 4. Each memory wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately: no further pc_en, reg_write or mem_write is issued.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum
  - opcode constants: OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI
  - funct constants
  - 3-bit ALU codes: ADD = 000, SUB = 001, AND = 010, OR = 011, SLT = 100
  - alu_src_b and pc_source encodings
- One natural sub-module, alu_decode: combinational mapping of (state class, opcode, funct) to alu_op plus a valid bit. It is shared with the future pipelined core.

Test Plan:
- Reset, then release with mem_ready = 1 and opcode 0x00, funct 0x20:
  - IDLE is seen for 1 cycle, then FETCH.
  - reg_write = 1 with reg_dst = 1 in cycle 4 after FETCH entry.
  - retired = 1.
- LW (opcode 0x23) with mem_ready low for 3 cycles in MEM_READ:
  - mem_read and iord held for 4 cycles.
  - MEM_WB asserts mem_to_reg = 1 and reg_write = 1.
  - 8 cycles total.
- BEQ (opcode 0x04) with zero = 1, then again with zero = 0:
  - In BRANCH, pc_en = 1 with pc_source = 01 for the first case, pc_en = 0 for the second.
  - alu_op = SUB in both cases.
- ORI (opcode 0x0D): EXEC_I shows alu_src_b = 11 and alu_op = OR; I_WB has reg_dst = 0.
- Opcode 0x3F, then separately R-type with funct 0x00:
  - illegal rises in the cycle after DECODE (resp. EXEC_R).
  - FSM stays in HALT with all outputs 0 through 20 further cycles.
  - Only rst clears it.
- rst pulsed during MEM_WRITE wait: mem_write drops asynchronously, state returns to IDLE, retired = 0.
